// File: rtl/pob_pkg.sv
// rtl/pob_pkg.sv - shared op encoding, window size and channel ALU for parallel_out_bank
package pob_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLR   = 2'b10,
    OP_TOG   = 2'b11
  } pob_op_e;

  localparam int WIN_WORDS = 32;

  function automatic logic [15:0] pob_alu(input pob_op_e op, input logic [15:0] cur,
                                          input logic [15:0] d);
    case (op)
      OP_WRITE: return d;
      OP_SET:   return cur | d;
      OP_CLR:   return cur & ~d;
      default:  return cur ^ d;
    endcase
  endfunction

endpackage

// File: rtl/pob_channel.sv
// rtl/pob_channel.sv - one output channel: shadow, output register, op ALU and update pulse
module pob_channel
  import pob_pkg::*;
#(
  parameter int           W          = 16,
  parameter int           DOUBLE_BUF = 1,
  parameter logic [W-1:0] RESET_VAL  = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_op_valid,
  input  pob_op_e      i_op,
  input  logic [W-1:0] i_data,
  input  logic         i_commit,
  output logic [W-1:0] o_shadow,
  output logic [W-1:0] o_data_out,
  output logic         o_updated
);

  logic [W-1:0] r_shadow;
  logic [W-1:0] r_data_out;
  logic         r_updated;
  logic [W-1:0] w_base;
  logic [15:0]  w_alu;
  logic [W-1:0] w_result;

  // In direct mode the op reads and writes the live output; the shadow just mirrors it.
  assign w_base   = (DOUBLE_BUF != 0) ? r_shadow : r_data_out;
  assign w_alu    = pob_alu(i_op, 16'(w_base), 16'(i_data));
  assign w_result = w_alu[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow   <= RESET_VAL;
      r_data_out <= RESET_VAL;
      r_updated  <= 1'b0;
    end else begin
      r_updated <= 1'b0;
      if (i_op_valid) begin
        r_shadow <= w_result;
        if (DOUBLE_BUF == 0) begin
          r_data_out <= w_result;
          r_updated  <= 1'b1;
        end
      end else if (i_commit && (DOUBLE_BUF != 0)) begin
        r_data_out <= r_shadow;
        r_updated  <= 1'b1;
      end
    end
  end

  assign o_shadow   = r_shadow;
  assign o_data_out = r_data_out;
  assign o_updated  = r_updated;

endmodule

// File: rtl/parallel_out_bank.sv
// rtl/parallel_out_bank.sv - memory-mapped bank of N_CH parallel output channels with commit
module parallel_out_bank
  import pob_pkg::*;
#(
  parameter int           N_CH       = 2,
  parameter int           W          = 16,
  parameter logic [14:0]  BASE       = 15'h7FE0,
  parameter int           DOUBLE_BUF = 1,
  parameter logic [W-1:0] RESET_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       RegData,
  input  logic [14:0]       Address,
  input  logic              we,
  output logic              wren,
  output logic              hit,
  output logic [15:0]       RdData,
  output logic [N_CH*W-1:0] DataOut,
  output logic [N_CH-1:0]   Updated
);

  localparam int N_OPS = 4 * N_CH;
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [14:0]   w_off;
  logic          w_is_op;
  logic          w_is_commit;
  logic [CW-1:0] w_ch;
  pob_op_e       w_op;
  logic [W-1:0]  w_shadow [N_CH];
  logic [W-1:0]  w_dout   [N_CH];
  logic [15:0]   w_rd_next;
  logic [15:0]   r_rd_data;

  assign w_off       = Address - BASE;
  assign w_is_op     = (w_off < 15'(N_OPS));
  assign w_is_commit = (w_off == 15'(N_OPS));
  assign w_ch        = w_off[CW+1:2];
  assign w_op        = pob_op_e'(w_off[1:0]);

  assign hit  = w_is_op | w_is_commit;
  assign wren = we & ~hit;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pob_channel #(
      .W          (W),
      .DOUBLE_BUF (DOUBLE_BUF),
      .RESET_VAL  (RESET_VAL)
    ) u_channel (
      .clk        (clk),
      .rst        (rst),
      .i_op_valid (we && w_is_op && (w_ch == CW'(c))),
      .i_op       (w_op),
      .i_data     (RegData[W-1:0]),
      .i_commit   (we && w_is_commit && RegData[c]),
      .o_shadow   (w_shadow[c]),
      .o_data_out (w_dout[c]),
      .o_updated  (Updated[c])
    );
    assign DataOut[c*W +: W] = w_dout[c];
  end

  // Readback: op slot 00 returns the shadow, 01 the live output, everything else reads 0.
  always_comb begin
    w_rd_next = '0;
    if (w_is_op) begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_ch == CW'(c)) begin
          if (w_op == OP_WRITE)    w_rd_next[W-1:0] = w_shadow[c];
          else if (w_op == OP_SET) w_rd_next[W-1:0] = w_dout[c];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (hit && !we) begin
      r_rd_data <= w_rd_next;
    end
  end

  assign RdData = r_rd_data;

endmodule
